// File: rtl/sr_latch_pkg.sv
// Shared encodings and next-state function for the vectorised SR storage element.
package sr_latch_pkg;

  localparam int unsigned SR_RST_DOM = 0;
  localparam int unsigned SR_SET_DOM = 1;
  localparam int unsigned SR_HOLD    = 2;
  localparam int unsigned SR_TOGGLE  = 3;

  // Next value of one SR bit; unknown conflict modes fall back to reset dominant.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input int unsigned mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b00: nxt = q;
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      default: begin
        case (mode)
          SR_SET_DOM: nxt = 1'b1;
          SR_HOLD:    nxt = q;
          SR_TOGGLE:  nxt = ~q;
          default:    nxt = 1'b0;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_latch_cell.sv
// Single-bit clocked SR cell with asynchronous clear to its own reset bit.
module sr_cell
  import sr_latch_pkg::*;
#(
  parameter logic        RESET_VAL = 1'b0,
  parameter int unsigned CONFLICT  = SR_RST_DOM
) (
  input  logic clk,
  input  logic clr,
  input  logic s,
  input  logic r,
  output logic q
);

  // Stored bit: clear wins asynchronously, otherwise resolve the request at the edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q <= RESET_VAL;
    else     q <= sr_next(q, s, r, CONFLICT);
  end

endmodule

// File: rtl/sr_latch.sv
// WIDTH independent SR cells with a registered any-bit set/reset conflict flag.
module sr_latch
  import sr_latch_pkg::*;
#(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CONFLICT  = SR_RST_DOM
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             conflict
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("sr_latch: WIDTH must be in 1..64");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .RESET_VAL (RESET_VAL[i]),
      .CONFLICT  (CONFLICT)
    ) u_cell (
      .clk (clk),
      .clr (clr),
      .s   (S[i]),
      .r   (R[i]),
      .q   (Q[i])
    );
  end

  assign Qn = ~Q;

  // Conflict flag: registered OR of per-bit S&R, recomputed every cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) conflict <= 1'b0;
    else     conflict <= |(S & R);
  end

endmodule

// File: tb/tb_sr_latch.sv
// Scoreboard bench: four 8-bit instances, one per conflict mode, share S/R stimulus.
module tb_sr_latch;

  localparam logic [7:0] RV0 = 8'h00;
  localparam logic [7:0] RV1 = 8'h00;
  localparam logic [7:0] RV2 = 8'h00;
  localparam logic [7:0] RV3 = 8'h3C;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [7:0] s = 8'hFF;
  logic [7:0] r = 8'hFF;
  logic [3:0][7:0] q_a, qn_a;
  logic [3:0] conf_a;

  typedef struct packed {
    logic [3:0][7:0] q;
    logic            conf;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [3:0][7:0] rv_all;

  always #5 clk = ~clk;

  sr_latch #(.WIDTH(8), .RESET_VAL(RV0), .CONFLICT(0)) u_m0 (
    .clk(clk), .clr(clr), .S(s), .R(r), .Q(q_a[0]), .Qn(qn_a[0]), .conflict(conf_a[0]));
  sr_latch #(.WIDTH(8), .RESET_VAL(RV1), .CONFLICT(1)) u_m1 (
    .clk(clk), .clr(clr), .S(s), .R(r), .Q(q_a[1]), .Qn(qn_a[1]), .conflict(conf_a[1]));
  sr_latch #(.WIDTH(8), .RESET_VAL(RV2), .CONFLICT(2)) u_m2 (
    .clk(clk), .clr(clr), .S(s), .R(r), .Q(q_a[2]), .Qn(qn_a[2]), .conflict(conf_a[2]));
  sr_latch #(.WIDTH(8), .RESET_VAL(RV3), .CONFLICT(3)) u_m3 (
    .clk(clk), .clr(clr), .S(s), .R(r), .Q(q_a[3]), .Qn(qn_a[3]), .conflict(conf_a[3]));

  task automatic chk(input string name, input int mode, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s mode=%0d t=%0t actual=%h expected=%h", name, mode, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0][7:0] exp_q,
                         input logic exp_conf);
    for (int m = 0; m < 4; m++) begin
      chk({name, "_q"}, m, q_a[m], exp_q[m]);
      chk({name, "_qn"}, m, qn_a[m], ~exp_q[m]);
      chk({name, "_conflict"}, m, {7'd0, conf_a[m]}, {7'd0, exp_conf});
    end
  endtask

  // Independent reference for one bit of a given conflict mode.
  function automatic logic ref_bit(input logic q, input logic sb_, input logic rb,
                                   input int mode);
    if (sb_ && !rb) return 1'b1;
    if (!sb_ && rb) return 1'b0;
    if (!sb_ && !rb) return q;
    if (mode == 1) return 1'b1;
    if (mode == 2) return q;
    if (mode == 3) return !q;
    return 1'b0;
  endfunction

  task automatic step(input logic [7:0] sv, input logic [7:0] rv,
                      input logic [3:0][7:0] exp_q, input logic exp_conf);
    exp_t e;
    @(negedge clk);
    s = sv;
    r = rv;
    e.q = exp_q;
    e.conf = exp_conf;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every cycle is an output cycle; compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_all("sb", e.q, e.conf);
      end
    end
  end

  initial begin
    logic [3:0][7:0] mq;
    logic [7:0] rs, rr;
    rv_all = {RV3, RV2, RV1, RV0};

    // Clear held with S=R=all ones: edges ignored.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_all("reset_hold", rv_all, 1'b0);
    end
    @(negedge clk);
    s = '0;
    r = '0;
    clr = 1'b0;

    // Basic sequence on bit 0, then conflict runs from 1 (bit0) and 0 (bit1).
    step(8'h01, 8'h00, {8'h3D, 8'h01, 8'h01, 8'h01}, 1'b0);
    step(8'h00, 8'h00, {8'h3D, 8'h01, 8'h01, 8'h01}, 1'b0);
    step(8'h00, 8'h00, {8'h3D, 8'h01, 8'h01, 8'h01}, 1'b0);
    step(8'h01, 8'h01, {8'h3C, 8'h01, 8'h01, 8'h00}, 1'b1);
    step(8'h01, 8'h01, {8'h3D, 8'h01, 8'h01, 8'h00}, 1'b1);
    step(8'h00, 8'h01, {8'h3C, 8'h00, 8'h00, 8'h00}, 1'b0);
    step(8'h00, 8'h01, {8'h3C, 8'h00, 8'h00, 8'h00}, 1'b0);
    step(8'h01, 8'h00, {8'h3D, 8'h01, 8'h01, 8'h01}, 1'b0);
    step(8'h03, 8'h03, {8'h3E, 8'h01, 8'h03, 8'h00}, 1'b1);
    step(8'h03, 8'h03, {8'h3D, 8'h01, 8'h03, 8'h00}, 1'b1);
    step(8'h03, 8'h03, {8'h3E, 8'h01, 8'h03, 8'h00}, 1'b1);
    step(8'h00, 8'h00, {8'h3E, 8'h01, 8'h03, 8'h00}, 1'b0);
    // Vector independence.
    step(8'hAA, 8'h55, {8'hAA, 8'hAA, 8'hAA, 8'hAA}, 1'b0);
    step(8'h0F, 8'hF0, {8'h0F, 8'h0F, 8'h0F, 8'h0F}, 1'b0);
    step(8'h01, 8'h01, {8'h0E, 8'h0F, 8'h0F, 8'h0E}, 1'b1);
    step(8'hFF, 8'hFF, {8'hF1, 8'h0F, 8'hFF, 8'h00}, 1'b1);
    step(8'h00, 8'h00, {8'hF1, 8'h0F, 8'hFF, 8'h00}, 1'b0);
    step(8'hFF, 8'hFF, {8'h0E, 8'h0F, 8'hFF, 8'h00}, 1'b1);
    drain();

    // Mid-cycle asynchronous clear with conflict=1 and Q nonzero.
    #1;
    clr = 1'b1;
    #1;
    chk_all("async_clr", rv_all, 1'b0);
    s = 8'hFF;
    r = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #2;
      chk_all("clr_dominates_set", rv_all, 1'b0);
    end
    @(negedge clk);
    s = '0;
    r = '0;
    clr = 1'b0;

    // Random S/R against the reference model.
    mq = rv_all;
    for (int c = 0; c < 200; c++) begin
      rs = 8'($urandom);
      rr = 8'($urandom);
      for (int m = 0; m < 4; m++)
        for (int b = 0; b < 8; b++)
          mq[m][b] = ref_bit(mq[m][b], rs[b], rr[b], m);
      step(rs, rr, mq, |(rs & rr));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
